// File: rtl/fetch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_hazard_ctrl
// Purpose  : Fetch/pipeline sequencing control. Resolves load-use stalls,
//            MEM-stage branch redirects and debug halt/single-step into PC
//            stall, redirect and per-stage flush/stall controls, and keeps
//            saturating stall/flush statistics.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             CPUCLK,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             mem_branch_taken,
    input  logic [31:0]      mem_branch_target,
    input  logic             dbg_halt_req,
    input  logic             dbg_step,
    output logic             pc_stall,
    output logic             branch_confirm,
    output logic [31:0]      branch_addr,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] c_RUN     = 2'd0;
    localparam logic [1:0] c_LDSTALL = 2'd1;
    localparam logic [1:0] c_HALT    = 2'd2;
    localparam logic [1:0] c_STEP    = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    logic             w_luh;
    logic             w_pc_stall;
    logic             w_ifid_stall;
    logic             w_ifid_flush;
    logic             w_idex_flush;
    logic             w_exmem_flush;
    logic             w_branch_confirm;
    logic [31:0]      w_branch_addr;

    // A load in EX whose destination is a live source of the ID instruction.
    // r0 is hardwired zero, so it never creates a dependency.
    assign w_luh = ex_mem_read && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Next-state and control decode; branch overrides everything, reset gates all.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_stall       = 1'b0;
        w_ifid_stall     = 1'b0;
        w_ifid_flush     = 1'b0;
        w_idex_flush     = 1'b0;
        w_exmem_flush    = 1'b0;
        w_branch_confirm = 1'b0;
        w_branch_addr    = 32'd0;

        case (r_state)
            c_RUN: begin
                if (w_luh) begin
                    w_pc_stall   = 1'b1;
                    w_ifid_stall = 1'b1;
                    w_idex_flush = 1'b1;
                    w_state_nxt  = c_LDSTALL;
                end
                if (dbg_halt_req && !mem_branch_taken) begin
                    w_state_nxt = c_HALT;
                end else if (mem_branch_taken) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_LDSTALL: begin
                // The stalled instruction re-issues here; the load has moved on.
                w_state_nxt = (dbg_halt_req && !mem_branch_taken) ? c_HALT : c_RUN;
            end
            c_HALT: begin
                w_pc_stall   = 1'b1;
                w_ifid_stall = 1'b1;
                w_idex_flush = 1'b1;
                if (!dbg_halt_req) begin
                    w_state_nxt = c_RUN;
                end else if (dbg_step) begin
                    w_state_nxt = c_STEP;
                end
            end
            default: begin
                // STEP: one released fetch; a load-use costs this cycle only.
                if (w_luh) begin
                    w_pc_stall   = 1'b1;
                    w_ifid_stall = 1'b1;
                    w_idex_flush = 1'b1;
                end
                w_state_nxt = dbg_halt_req ? c_HALT : c_RUN;
            end
        endcase

        if (mem_branch_taken) begin
            w_branch_confirm = 1'b1;
            w_branch_addr    = mem_branch_target;
            w_ifid_flush     = 1'b1;
            w_idex_flush     = 1'b1;
            w_exmem_flush    = 1'b1;
            w_pc_stall       = 1'b0;
            w_ifid_stall     = 1'b0;
        end

        if (reset) begin
            w_pc_stall       = 1'b0;
            w_ifid_stall     = 1'b0;
            w_ifid_flush     = 1'b0;
            w_idex_flush     = 1'b0;
            w_exmem_flush    = 1'b0;
            w_branch_confirm = 1'b0;
            w_branch_addr    = 32'd0;
        end
    end

    // Sequencer state and saturating statistics counters.
    always_ff @(posedge CPUCLK or posedge reset) begin
        if (reset) begin
            r_state       <= c_RUN;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pc_stall && (r_stall_count != c_CNT_MAX)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (w_branch_confirm && (r_flush_count != c_CNT_MAX)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign pc_stall       = w_pc_stall;
    assign ifid_stall     = w_ifid_stall;
    assign ifid_flush     = w_ifid_flush;
    assign idex_flush     = w_idex_flush;
    assign exmem_flush    = w_exmem_flush;
    assign branch_confirm = w_branch_confirm;
    assign branch_addr    = w_branch_addr;
    assign halted         = (r_state == c_HALT) || (r_state == c_STEP);
    assign stall_count    = r_stall_count;
    assign flush_count    = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_hazard_ctrl
// Purpose  : Directed self-checking bench for fetch_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_hazard_ctrl;

    logic        CPUCLK = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, mem_branch_taken;
    logic [31:0] mem_branch_target;
    logic        dbg_halt_req, dbg_step;
    logic        pc_stall, branch_confirm, ifid_stall, ifid_flush;
    logic        idex_flush, exmem_flush, halted;
    logic [31:0] branch_addr;
    logic [15:0] stall_count, flush_count;

    int tests  = 0;
    int fails  = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    // {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush, branch_confirm, halted}
    logic [6:0] ctl;
    assign ctl = {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush, branch_confirm, halted};

    localparam logic [6:0] CTL_IDLE   = 7'b0000000;
    localparam logic [6:0] CTL_LUH    = 7'b1101000;
    localparam logic [6:0] CTL_HALT   = 7'b1101001;
    localparam logic [6:0] CTL_STEP   = 7'b0000001;
    localparam logic [6:0] CTL_BRANCH = 7'b0011110;

    fetch_hazard_ctrl #(.CNT_W(16), .REG_W(5)) dut (
        .CPUCLK            (CPUCLK),
        .reset             (reset),
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .id_uses_rt        (id_uses_rt),
        .ex_mem_read       (ex_mem_read),
        .ex_rt             (ex_rt),
        .mem_branch_taken  (mem_branch_taken),
        .mem_branch_target (mem_branch_target),
        .dbg_halt_req      (dbg_halt_req),
        .dbg_step          (dbg_step),
        .pc_stall          (pc_stall),
        .branch_confirm    (branch_confirm),
        .branch_addr       (branch_addr),
        .ifid_stall        (ifid_stall),
        .ifid_flush        (ifid_flush),
        .idex_flush        (idex_flush),
        .exmem_flush       (exmem_flush),
        .halted            (halted),
        .stall_count       (stall_count),
        .flush_count       (flush_count)
    );

    always #5 CPUCLK = ~CPUCLK;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CPUCLK);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        mem_branch_taken = 1'b0; mem_branch_target = 32'd0;
        dbg_halt_req = 1'b0; dbg_step = 1'b0;
    endtask

    task automatic test_reset();
        // Get into HALT with a nonzero stall count.
        dbg_halt_req = 1'b1;
        tick();              // RUN -> HALT
        tick();              // one HALT cycle counted
        mem_branch_taken  = 1'b1;
        mem_branch_target = 32'h0000_1234;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (ctl !== CTL_IDLE) begin
                fails++; $display("FAIL reset_ctl[%0d]: got %b expected %b", i, ctl, CTL_IDLE);
            end
            tests++;
            if (branch_addr !== 32'd0) begin
                fails++; $display("FAIL reset_addr[%0d]: got %h expected 0", i, branch_addr);
            end
            tests++;
            if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
                fails++; $display("FAIL reset_cnt[%0d]: got %0d/%0d expected 0/0", i, stall_count, flush_count);
            end
            tick();
        end
        clear_inputs();
        reset = 1'b0;
        #1;
        tests++;
        if (ctl !== CTL_IDLE) begin
            fails++; $display("FAIL reset_release_ctl: got %b expected %b", ctl, CTL_IDLE);
        end
        tick();
        tests++;
        if (ctl !== CTL_IDLE || stall_count !== 16'd0 || flush_count !== 16'd0) begin
            fails++; $display("FAIL reset_release_state: ctl %b cnt %0d/%0d expected %b 0/0",
                              ctl, stall_count, flush_count, CTL_IDLE);
        end
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        tests++;
        if (ctl !== CTL_LUH) begin
            fails++; $display("FAIL luh_stall: got %b expected %b", ctl, CTL_LUH);
        end
        tick();
        exp_stall++;
        tests++;
        if (ctl !== CTL_IDLE) begin
            fails++; $display("FAIL luh_ldstall_idle: got %b expected %b", ctl, CTL_IDLE);
        end
        tests++;
        if (stall_count !== 16'(exp_stall)) begin
            fails++; $display("FAIL luh_count: got %0d expected %0d", stall_count, exp_stall);
        end
        tick();
        // Destination r0 never stalls.
        ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        tests++;
        if (ctl !== CTL_IDLE) begin
            fails++; $display("FAIL luh_r0: got %b expected %b", ctl, CTL_IDLE);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_rt_use();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        tests++;
        if (ctl !== CTL_IDLE) begin
            fails++; $display("FAIL rt_unused: got %b expected %b", ctl, CTL_IDLE);
        end
        id_uses_rt = 1'b1;
        #1;
        tests++;
        if (ctl !== CTL_LUH) begin
            fails++; $display("FAIL rt_used: got %b expected %b", ctl, CTL_LUH);
        end
        tick();
        exp_stall++;
        clear_inputs();
        tick();
        tests++;
        if (stall_count !== 16'(exp_stall)) begin
            fails++; $display("FAIL rt_count: got %0d expected %0d", stall_count, exp_stall);
        end
    endtask

    task automatic test_branch_priority();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        mem_branch_taken = 1'b1; mem_branch_target = 32'h0000_0040;
        #1;
        tests++;
        if (ctl !== CTL_BRANCH) begin
            fails++; $display("FAIL br_ctl: got %b expected %b", ctl, CTL_BRANCH);
        end
        tests++;
        if (branch_addr !== 32'h0000_0040) begin
            fails++; $display("FAIL br_addr: got %h expected 00000040", branch_addr);
        end
        tick();
        exp_flush++;
        clear_inputs();
        #1;
        tests++;
        if (flush_count !== 16'(exp_flush) || stall_count !== 16'(exp_stall)) begin
            fails++; $display("FAIL br_counts: got %0d/%0d expected %0d/%0d",
                              flush_count, stall_count, exp_flush, exp_stall);
        end
        tests++;
        if (ctl !== CTL_IDLE || branch_addr !== 32'd0) begin
            fails++; $display("FAIL br_after: ctl %b addr %h expected %b 0", ctl, branch_addr, CTL_IDLE);
        end
        tick();
    endtask

    task automatic test_halt_step();
        logic [6:0] exp [0:6];
        exp[0] = CTL_IDLE; exp[1] = CTL_HALT; exp[2] = CTL_HALT; exp[3] = CTL_STEP;
        exp[4] = CTL_HALT; exp[5] = CTL_HALT; exp[6] = CTL_IDLE;
        // Step ignored outside HALT.
        dbg_step = 1'b1;
        tick();
        dbg_step = 1'b0;
        #1;
        tests++;
        if (ctl !== CTL_IDLE) begin
            fails++; $display("FAIL step_in_run: got %b expected %b", ctl, CTL_IDLE);
        end
        for (int c = 0; c < 7; c++) begin
            dbg_halt_req = (c < 5);
            dbg_step     = (c == 2);
            #1;
            tests++;
            if (ctl !== exp[c]) begin
                fails++; $display("FAIL halt_cycle%0d: got %b expected %b", c, ctl, exp[c]);
            end
            if (exp[c][6]) exp_stall++;
            tick();
        end
        clear_inputs();
        tests++;
        if (stall_count !== 16'(exp_stall)) begin
            fails++; $display("FAIL halt_count: got %0d expected %0d", stall_count, exp_stall);
        end
    endtask

    task automatic test_saturation();
        dbg_halt_req = 1'b1;
        repeat (65536 + 3 + 1) tick();
        tests++;
        if (stall_count !== 16'hFFFF) begin
            fails++; $display("FAIL sat_hold: got %h expected ffff", stall_count);
        end
        dbg_halt_req = 1'b0;
        tick();
        tick();
        tests++;
        if (stall_count !== 16'hFFFF || halted !== 1'b0) begin
            fails++; $display("FAIL sat_nowrap: got %h halted %b expected ffff 0", stall_count, halted);
        end
        tests++;
        if (flush_count !== 16'(exp_flush)) begin
            fails++; $display("FAIL sat_flush: got %0d expected %0d", flush_count, exp_flush);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if (ctl !== CTL_IDLE || stall_count !== 16'd0 || flush_count !== 16'd0) begin
            fails++; $display("FAIL por_state: ctl %b cnt %0d/%0d expected %b 0/0",
                              ctl, stall_count, flush_count, CTL_IDLE);
        end
        test_reset();
        test_load_use();
        test_rt_use();
        test_branch_priority();
        test_halt_step();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
- Pipeline control block that sequences the instruction-fetch stage and the pipeline registers behind it.
- Generates the PC stall, branch redirect (branch_confirm/branch_addr) and per-stage flush/stall controls.
- Sources: load-use hazards, branches resolved in MEM, and a debug halt/single-step port.
- Also keeps saturating statistics counters for stalled cycles and taken-branch flushes.

Parameters:
CNT_W, 16, width of stall_count and flush_count
REG_W, 5, register specifier width

Ports:
CPUCLK  in  1  pipeline clock; state and counters update on rising edge
reset  in  1  asynchronous, active-high; clock CPUCLK
id_rs  in  REG_W  rs field of instruction in ID
id_rt  in  REG_W  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_mem_read  in  1  EX instruction is a load
ex_rt  in  REG_W  destination (rt) of EX load
mem_branch_taken  in  1  branch in MEM resolved taken
mem_branch_target  in  32  branch target from MEM
dbg_halt_req  in  1  level; request fetch halt
dbg_step  in  1  single-cycle pulse; release one fetch while halted
pc_stall  out  1  hold PC
branch_confirm  out  1  redirect PC to branch_addr
branch_addr  out  32  redirect target
ifid_stall  out  1  hold IF/ID register
ifid_flush  out  1  zero IF/ID register
idex_flush  out  1  insert bubble into ID/EX
exmem_flush  out  1  zero EX/MEM register
halted  out  1  FSM in HALT or STEP
stall_count  out  CNT_W  saturating count of stalled cycles
flush_count  out  CNT_W  saturating count of taken-branch redirects

Behaviour:
- Control outputs are combinational from the registered state plus current inputs, so IF sees them before the next CPUCLK edge. Only the state and counters are registered.
- Reset (asynchronous): state=RUN, counters=0, all control outputs forced 0, branch_addr=0 while reset is high.
- Load-use hit (luh): ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Priority, highest first: branch > halt/step > load-use.
- Branch, any state: mem_branch_taken=1 gives the following in the same cycle:
  - branch_confirm=1, branch_addr=mem_branch_target;
  - ifid_flush=idex_flush=exmem_flush=1;
  - pc_stall=0, ifid_stall=0;
  - flush_count+1 (saturates at all-ones).
- States:
  - RUN: luh -> pc_stall=ifid_stall=idex_flush=1; next LDSTALL. dbg_halt_req=1 with no branch -> next HALT (outputs this cycle per RUN rules). Otherwise all controls 0.
  - LDSTALL: exactly one cycle; luh is ignored and all controls are 0 (re-fetch proceeds). Next RUN, or HALT if dbg_halt_req=1.
  - HALT: pc_stall=ifid_stall=idex_flush=1 every cycle, so older instructions drain and bubbles are injected.
    - dbg_halt_req=0 -> next RUN.
    - dbg_step=1 -> next STEP.
  - STEP: one cycle with controls as in RUN, except luh is honoured as a one-cycle stall without entering LDSTALL. Next HALT if dbg_halt_req=1, else RUN.
- A branch in HALT/STEP is honoured; the state is unchanged by the branch, except STEP still returns to HALT/RUN.
- branch_addr is 0 whenever branch_confirm=0.
- stall_count: +1 each cycle pc_stall=1; saturates at all-ones; never wraps.
- halted=1 in HALT and STEP.
- Reset mid-stall or mid-halt: immediate return to RUN with counters cleared; no pending step is remembered.
- dbg_step outside HALT is ignored.

Test Plan:
- Reset asserted for 3 cycles mid-HALT, with mem_branch_taken=1 -> all outputs 0 during reset, state RUN, counters 0 after release.
- ex_mem_read=1, ex_rt=8, id_rs=8 -> pc_stall=ifid_stall=idex_flush=1 for exactly 1 cycle, next cycle all 0, stall_count=1. Repeat with ex_rt=0 -> no stall.
- luh and mem_branch_taken=1, target 0x40, in the same cycle -> branch_confirm=1, branch_addr=0x40, three flushes=1, pc_stall=0, flush_count=1, stall_count unchanged.
- dbg_halt_req=1 for 5 cycles, dbg_step pulse at cycle 3 -> halted=1, pc_stall=1 except the single STEP cycle (pc_stall=0), then HALT resumes; deassert -> RUN next cycle.
- Force 2^CNT_W+3 stalled cycles via halt -> stall_count holds 0xFFFF, no wrap.
- id_uses_rt=0, ex_rt=id_rt=5, id_rs=3, ex_mem_read=1 -> no stall.
